reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_reg_write_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Merges writeback-stage writes and jump-and-link return-address writes
//   onto a single register-file write port. When both arrive in the same
//   cycle, or earlier writes are still waiting, the extra writes go into a
//   2-entry in-order FIFO. Buffered writes are forwarded to the decode
//   stage read ports until they retire.
//
// Ports
//   Clk, Rst_n                  clock, async active-low reset
//   WbValid/WbReg/WbData        writeback write request
//   LinkValid/LinkData          link write request (destination LINK_REG)
//   RdReg1, RdReg2              decode-stage read indices
//   RfWrite/RfReg/RfData        register-file write port (combinational)
//   Fwd1Valid/Data, Fwd2*       youngest buffered value for each read index
//   Stall                       FIFO full; no Link request may be issued
//   PendingCount                number of buffered writes (0..2)
//   Overflow                    sticky: a Link request arrived while stalled
//
// State
//   PendingCount | meaning
//   0            | empty, requests pass straight through
//   1            | head entry is written this cycle, new requests queue behind it
//   2            | full, Stall asserted, Link requests are dropped
module reg_write_arbiter #(
    parameter logic [4:0] LINK_REG = 5'd31
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        WbValid,
    input  logic [4:0]  WbReg,
    input  logic [31:0] WbData,
    input  logic        LinkValid,
    input  logic [31:0] LinkData,
    input  logic [4:0]  RdReg1,
    input  logic [4:0]  RdReg2,
    output logic        RfWrite,
    output logic [4:0]  RfReg,
    output logic [31:0] RfData,
    output logic        Fwd1Valid,
    output logic [31:0] Fwd1Data,
    output logic        Fwd2Valid,
    output logic [31:0] Fwd2Data,
    output logic        Stall,
    output logic [1:0]  PendingCount,
    output logic        Overflow
);

    // FIFO storage: index 0 is always the head (oldest entry).
    logic [4:0]  r_reg  [2];
    logic [31:0] r_data [2];
    logic [1:0]  r_count;
    logic        r_overflow;

    logic        w_stall;
    logic        w_have_head;
    logic        w_wb_req;
    logic        w_link_req;
    logic        w_wb_push;
    logic        w_link_push;

    logic [4:0]  w_nxt_reg  [2];
    logic [31:0] w_nxt_data [2];
    logic [1:0]  w_nxt_count;

    assign w_stall     = (r_count == 2'd2);
    assign w_have_head = (r_count != 2'd0);

    // Writes to register 0 are architecturally meaningless and vanish here.
    assign w_wb_req   = WbValid && (WbReg != 5'd0);
    assign w_link_req = LinkValid && !w_stall && (LINK_REG != 5'd0);

    // Anything not served this cycle is queued, WB ahead of Link.
    assign w_wb_push   = w_wb_req && w_have_head;
    assign w_link_push = w_link_req && (w_have_head || w_wb_req);

    always_comb begin
        RfWrite = 1'b0;
        RfReg   = 5'd0;
        RfData  = 32'd0;
        if (Rst_n) begin
            if (w_have_head) begin
                RfWrite = 1'b1;
                RfReg   = r_reg[0];
                RfData  = r_data[0];
            end else if (w_wb_req) begin
                RfWrite = 1'b1;
                RfReg   = WbReg;
                RfData  = WbData;
            end else if (w_link_req) begin
                RfWrite = 1'b1;
                RfReg   = LINK_REG;
                RfData  = LinkData;
            end
        end
    end

    // Next FIFO contents: pop the head if one exists, shift, then append
    // the pushed requests. The full case can only take a WB push, since
    // Link is dropped while stalled, so the count never exceeds 2.
    always_comb begin
        logic [1:0] w_slot;
        w_nxt_reg[0]  = r_reg[0];
        w_nxt_reg[1]  = r_reg[1];
        w_nxt_data[0] = r_data[0];
        w_nxt_data[1] = r_data[1];
        w_slot        = r_count;
        if (w_have_head) begin
            w_slot = r_count - 2'd1;
            if (r_count == 2'd2) begin
                w_nxt_reg[0]  = r_reg[1];
                w_nxt_data[0] = r_data[1];
            end
        end
        if (w_wb_push) begin
            if (w_slot == 2'd0) begin
                w_nxt_reg[0]  = WbReg;
                w_nxt_data[0] = WbData;
            end else begin
                w_nxt_reg[1]  = WbReg;
                w_nxt_data[1] = WbData;
            end
            w_slot = w_slot + 2'd1;
        end
        if (w_link_push) begin
            if (w_slot == 2'd0) begin
                w_nxt_reg[0]  = LINK_REG;
                w_nxt_data[0] = LinkData;
            end else begin
                w_nxt_reg[1]  = LINK_REG;
                w_nxt_data[1] = LinkData;
            end
            w_slot = w_slot + 2'd1;
        end
        w_nxt_count = w_slot;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_reg[0]   <= 5'd0;
            r_reg[1]   <= 5'd0;
            r_data[0]  <= 32'd0;
            r_data[1]  <= 32'd0;
            r_count    <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            r_reg[0]   <= w_nxt_reg[0];
            r_reg[1]   <= w_nxt_reg[1];
            r_data[0]  <= w_nxt_data[0];
            r_data[1]  <= w_nxt_data[1];
            r_count    <= w_nxt_count;
            if (LinkValid && w_stall) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Youngest matching buffered entry wins; the head still forwards in
    // the cycle it is being written because the register file has not
    // captured it yet.
    function automatic logic [32:0] fwd_lookup(input logic [4:0] rd);
        logic [32:0] res;
        res = 33'd0;
        if (rd != 5'd0) begin
            if (r_count != 2'd0 && r_reg[0] == rd) begin
                res = {1'b1, r_data[0]};
            end
            if (r_count == 2'd2 && r_reg[1] == rd) begin
                res = {1'b1, r_data[1]};
            end
        end
        return res;
    endfunction

    always_comb begin
        {Fwd1Valid, Fwd1Data} = fwd_lookup(RdReg1);
        {Fwd2Valid, Fwd2Data} = fwd_lookup(RdReg2);
    end

    assign Stall        = w_stall;
    assign PendingCount = r_count;
    assign Overflow     = r_overflow;

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

    localparam logic [4:0] LINK = 5'd31;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        WbValid = 1'b0;
    logic [4:0]  WbReg = 5'd0;
    logic [31:0] WbData = 32'd0;
    logic        LinkValid = 1'b0;
    logic [31:0] LinkData = 32'd0;
    logic [4:0]  RdReg1 = 5'd0;
    logic [4:0]  RdReg2 = 5'd0;
    logic        RfWrite;
    logic [4:0]  RfReg;
    logic [31:0] RfData;
    logic        Fwd1Valid;
    logic [31:0] Fwd1Data;
    logic        Fwd2Valid;
    logic [31:0] Fwd2Data;
    logic        Stall;
    logic [1:0]  PendingCount;
    logic        Overflow;

    reg_write_arbiter #(.LINK_REG(LINK)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .WbValid(WbValid), .WbReg(WbReg), .WbData(WbData),
        .LinkValid(LinkValid), .LinkData(LinkData),
        .RdReg1(RdReg1), .RdReg2(RdReg2),
        .RfWrite(RfWrite), .RfReg(RfReg), .RfData(RfData),
        .Fwd1Valid(Fwd1Valid), .Fwd1Data(Fwd1Data),
        .Fwd2Valid(Fwd2Valid), .Fwd2Data(Fwd2Data),
        .Stall(Stall), .PendingCount(PendingCount), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t m_q[$];
    bit   m_ovf;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Pending writes plus this cycle's arrivals, in program order; the first
    // is written now, the rest remain pending.
    task automatic model_check();
        ent_t        all[$];
        bit          stalled;
        bit          fv;
        logic [31:0] fd;
        logic [4:0]  rd;
        all = m_q;
        stalled = (m_q.size() == 2);
        if (WbValid && WbReg != 5'd0) all.push_back('{r: WbReg, d: WbData});
        if (LinkValid && !stalled) all.push_back('{r: LINK, d: LinkData});

        chk("rf_write", 32'(RfWrite), 32'(all.size() > 0));
        chk("rf_reg",   32'(RfReg),   all.size() > 0 ? 32'(all[0].r) : 32'd0);
        chk("rf_data",  RfData,       all.size() > 0 ? all[0].d : 32'd0);
        chk("pending",  32'(PendingCount), 32'(m_q.size()));
        chk("stall",    32'(Stall),   32'(stalled));
        chk("overflow", 32'(Overflow), 32'(m_ovf));

        for (int p = 0; p < 2; p++) begin
            rd = (p == 0) ? RdReg1 : RdReg2;
            fv = 0;
            fd = 32'd0;
            if (rd != 5'd0) begin
                for (int i = m_q.size() - 1; i >= 0; i--) begin
                    if (!fv && m_q[i].r == rd) begin
                        fv = 1;
                        fd = m_q[i].d;
                    end
                end
            end
            if (p == 0) begin
                chk("fwd1_valid", 32'(Fwd1Valid), 32'(fv));
                chk("fwd1_data",  Fwd1Data, fd);
            end else begin
                chk("fwd2_valid", 32'(Fwd2Valid), 32'(fv));
                chk("fwd2_data",  Fwd2Data, fd);
            end
        end

        if (all.size() > 0) void'(all.pop_front());
        m_q = all;
        if (LinkValid && stalled) m_ovf = 1;
    endtask

    task automatic cycle(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                         input logic lv, input logic [31:0] ld,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge Clk);
        WbValid = wv; WbReg = wr; WbData = wd;
        LinkValid = lv; LinkData = ld;
        RdReg1 = r1; RdReg2 = r2;
        #1;
        model_check();
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd0, 5'd0);
    endtask

    // Reset asserted mid-cycle with live requests on the inputs: outputs must
    // collapse immediately, not at the next edge.
    task automatic do_reset();
        @(negedge Clk);
        #2;
        WbValid = 1'b1; WbReg = 5'd3; WbData = 32'hDEAD;
        LinkValid = 1'b1; LinkData = 32'hBEEF;
        RdReg1 = LINK; RdReg2 = 5'd3;
        Rst_n = 1'b0;
        #1;
        chk("rst_rf_write", 32'(RfWrite), 32'd0);
        chk("rst_pending",  32'(PendingCount), 32'd0);
        chk("rst_stall",    32'(Stall), 32'd0);
        chk("rst_overflow", 32'(Overflow), 32'd0);
        chk("rst_fwd1",     32'(Fwd1Valid), 32'd0);
        chk("rst_fwd2",     32'(Fwd2Valid), 32'd0);
        m_q.delete();
        m_ovf = 0;
        @(negedge Clk);
        WbValid = 1'b0; LinkValid = 1'b0;
        Rst_n = 1'b1;
    endtask

    initial begin
        logic       wv, lv;
        logic [4:0] wr, r1, r2;
        m_ovf = 0;
        #12;
        Rst_n = 1'b1;

        // Empty FIFO pass-through.
        cycle(1'b1, 5'd8, 32'hA5, 1'b0, 32'd0, 5'd0, 5'd0);
        chk("pass_write", 32'(RfWrite), 32'd1);
        chk("pass_reg",   32'(RfReg), 32'd8);
        chk("pass_data",  RfData, 32'hA5);
        idle();
        chk("pass_count_after", 32'(PendingCount), 32'd0);

        // Single collision, then forwarding of the buffered link value.
        cycle(1'b1, 5'd5, 32'h11, 1'b1, 32'h400, 5'd0, 5'd0);
        chk("col_c0_reg",  32'(RfReg), 32'd5);
        chk("col_c0_data", RfData, 32'h11);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd31, 5'd0);
        chk("col_c1_count", 32'(PendingCount), 32'd1);
        chk("col_c1_reg",   32'(RfReg), 32'd31);
        chk("col_c1_data",  RfData, 32'h400);
        chk("fwd_lit_v1",   32'(Fwd1Valid), 32'd1);
        chk("fwd_lit_d1",   Fwd1Data, 32'h400);
        chk("fwd_lit_v2",   32'(Fwd2Valid), 32'd0);
        idle();
        chk("col_c2_count", 32'(PendingCount), 32'd0);

        // Back-to-back collisions: four writes in program order.
        cycle(1'b1, 5'd1, 32'h101, 1'b1, 32'h1001, 5'd0, 5'd0);
        chk("b2b_w0", {RfReg, RfData[26:0]}, {5'd1, 27'h101});
        cycle(1'b1, 5'd2, 32'h202, 1'b1, 32'h1002, 5'd0, 5'd0);
        chk("b2b_cnt1", 32'(PendingCount), 32'd1);
        chk("b2b_w1", {RfReg, RfData[26:0]}, {5'd31, 27'h1001});
        idle();
        chk("b2b_cnt2",  32'(PendingCount), 32'd2);
        chk("b2b_stall", 32'(Stall), 32'd1);
        chk("b2b_w2", {RfReg, RfData[26:0]}, {5'd2, 27'h202});
        idle();
        chk("b2b_w3", {RfReg, RfData[26:0]}, {5'd31, 27'h1002});
        idle();
        chk("b2b_drained", 32'(RfWrite), 32'd0);

        // Link while stalled is dropped and flags Overflow.
        cycle(1'b1, 5'd6, 32'h66, 1'b1, 32'h2000, 5'd0, 5'd0);
        cycle(1'b1, 5'd7, 32'h77, 1'b1, 32'h2004, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 32'h2008, 5'd0, 5'd0);
        chk("ovf_stall", 32'(Stall), 32'd1);
        idle();
        chk("ovf_flag",  32'(Overflow), 32'd1);
        chk("ovf_count", 32'(PendingCount), 32'd1);
        idle();
        cycle(1'b1, 5'd0, 32'h99, 1'b0, 32'd0, 5'd0, 5'd0);
        chk("r0_no_write", 32'(RfWrite), 32'd0);
        idle();
        chk("r0_no_push", 32'(PendingCount), 32'd0);
        chk("ovf_sticky", 32'(Overflow), 32'd1);

        // Reset with a full FIFO.
        cycle(1'b1, 5'd9, 32'h9, 1'b1, 32'h3000, 5'd0, 5'd0);
        cycle(1'b1, 5'd10, 32'hA, 1'b1, 32'h3004, 5'd0, 5'd0);
        idle();
        chk("pre_rst_count", 32'(PendingCount), 32'd2);
        do_reset();
        idle();
        chk("post_rst_no_stale", 32'(RfWrite), 32'd0);
        chk("post_rst_ovf",      32'(Overflow), 32'd0);

        // Randomized traffic, with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                wv = ($urandom_range(0, 99) < 60);
                lv = ($urandom_range(0, 99) < 35);
                wr = ($urandom_range(0, 7) == 0) ? 5'd0 :
                     (($urandom_range(0, 5) == 0) ? LINK : 5'($urandom_range(1, 6)));
                r1 = ($urandom_range(0, 3) == 0) ? LINK : 5'($urandom_range(0, 6));
                r2 = 5'($urandom_range(0, 31));
                cycle(wv, wr, $urandom, lv, $urandom, r1, r2);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
